closest_hit_reducer: RTL and testbench

//   Multi-lane closest-hit accumulator that sits after LANES parallel intersection pipelines.
//   For one batch of i_tri_cnt triangle results it keeps the smallest hit distance t and
//   the triangle index that produced it, then raises o_finish once every result has arrived.

---
 rtl/closest_hit_reducer_if.sv | 39 +++
 rtl/closest_hit_reducer.sv | 195 +++++++++++++++++++
 tb/tb_closest_hit_reducer.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/closest_hit_reducer_if.sv
// Bundle of batch-control, lane-result and best-hit signals for closest_hit_reducer.
// The optional o_hit_cnt signal exists only when HIT_REDUCE_COUNT_EN is defined.
interface closest_hit_reducer_if #(
    parameter int LANES = 4,
    parameter int T_W   = 32,
    parameter int IDX_W = 32
);
    logic                   i_start;
    logic [IDX_W-1:0]       i_tri_cnt;
    logic [LANES-1:0]       i_valid;
    logic [LANES-1:0]       i_hit;
    logic [LANES*T_W-1:0]   i_t;
    logic [LANES*IDX_W-1:0] i_idx;
    logic                   o_busy;
    logic                   o_hit;
    logic [T_W-1:0]         o_t;
    logic [IDX_W-1:0]       o_idx;
    logic                   o_finish;
    logic                   o_err;
`ifdef HIT_REDUCE_COUNT_EN
    logic [IDX_W-1:0]       o_hit_cnt;
`endif

    modport master (
        output i_start, i_tri_cnt, i_valid, i_hit, i_t, i_idx,
`ifdef HIT_REDUCE_COUNT_EN
        input  o_hit_cnt,
`endif
        input  o_busy, o_hit, o_t, o_idx, o_finish, o_err
    );

    modport slave (
        input  i_start, i_tri_cnt, i_valid, i_hit, i_t, i_idx,
`ifdef HIT_REDUCE_COUNT_EN
        output o_hit_cnt,
`endif
        output o_busy, o_hit, o_t, o_idx, o_finish, o_err
    );
endinterface

// File: rtl/closest_hit_reducer.sv
// Multi-lane closest-hit accumulator: keeps the smallest signed t (and its triangle
// index) over a batch of results arriving up to LANES per cycle, flags protocol
// errors and raises o_finish when the batch is complete.
// Optional feature macro: HIT_REDUCE_COUNT_EN adds a saturating qualifying-hit counter.
module closest_hit_reducer #(
    parameter int        LANES = 4,
    parameter int        T_W   = 32,
    parameter int        IDX_W = 32,
    parameter int signed MIN_T = 0
) (
    input logic                  clk,
    input logic                  reset,
    closest_hit_reducer_if.slave bus
);
    localparam logic signed [T_W-1:0] T_MAX   = {1'b0, {(T_W-1){1'b1}}};
    localparam logic signed [T_W-1:0] T_FLOOR = T_W'(MIN_T);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                  state, state_next;
    logic [IDX_W-1:0]        rem, rem_next;
    logic [IDX_W-1:0]        valid_cnt;
    logic                    accept;
    logic                    err_set;
    logic                    finish_set;

    logic                    cand_v;
    logic signed [T_W-1:0]   cand_t;
    logic [IDX_W-1:0]        cand_idx;
    logic [LANES-1:0]        hit_lanes;
    logic signed [T_W-1:0]   lane_t;
    logic [IDX_W-1:0]        lane_idx;

    logic                    sv;
    logic signed [T_W-1:0]   st;
    logic [IDX_W-1:0]        sidx;

    logic                    best_hit;
    logic signed [T_W-1:0]   best_t;
    logic [IDX_W-1:0]        best_idx;
    logic                    finish;
    logic                    err;

    // Total ordering on (t, index) so the winner does not depend on lane order.
    function automatic logic better(input logic signed [T_W-1:0] ta,
                                    input logic [IDX_W-1:0]      ia,
                                    input logic signed [T_W-1:0] tb,
                                    input logic [IDX_W-1:0]      ib);
        return (ta < tb) || ((ta == tb) && (ia < ib));
    endfunction

    assign valid_cnt = IDX_W'($countones(bus.i_valid));

    // Lane tree: pick the best qualifying candidate among this cycle's lanes.
    always_comb begin
        cand_v    = 1'b0;
        cand_t    = T_MAX;
        cand_idx  = '0;
        hit_lanes = '0;
        lane_t    = '0;
        lane_idx  = '0;
        for (int n = 0; n < LANES; n++) begin
            lane_t   = $signed(bus.i_t[n*T_W +: T_W]);
            lane_idx = bus.i_idx[n*IDX_W +: IDX_W];
            if (bus.i_valid[n] && bus.i_hit[n] && (lane_t >= T_FLOOR)) begin
                hit_lanes[n] = 1'b1;
                if (!cand_v || better(lane_t, lane_idx, cand_t, cand_idx)) begin
                    cand_v   = 1'b1;
                    cand_t   = lane_t;
                    cand_idx = lane_idx;
                end
            end
        end
    end

    // Next-state logic: batch bookkeeping, error detection and completion.
    always_comb begin
        state_next = state;
        rem_next   = rem;
        accept     = 1'b0;
        err_set    = 1'b0;
        finish_set = 1'b0;
        if (bus.i_start) begin
            rem_next   = bus.i_tri_cnt;
            state_next = (bus.i_tri_cnt == '0) ? S_DONE : S_RUN;
        end else begin
            case (state)
                S_RUN: begin
                    accept = 1'b1;
                    if (valid_cnt > rem) begin
                        err_set  = 1'b1;
                        rem_next = '0;
                    end else begin
                        rem_next = rem - valid_cnt;
                    end
                    if (valid_cnt >= rem) begin
                        state_next = S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    err_set    = (bus.i_valid != '0);
                    finish_set = 1'b1;
                    state_next = S_DONE;
                end
                default: begin
                    err_set = (bus.i_valid != '0);
                end
            endcase
        end
    end

    // State and remaining-count registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            rem   <= '0;
        end else begin
            state <= state_next;
            rem   <= rem_next;
        end
    end

    // Stage register: holds this cycle's lane winner; a new batch discards it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sv   <= 1'b0;
            st   <= T_MAX;
            sidx <= '0;
        end else if (bus.i_start || !accept) begin
            sv <= 1'b0;
        end else begin
            sv   <= cand_v;
            st   <= cand_t;
            sidx <= cand_idx;
        end
    end

    // Best-hit merge plus sticky finish/error flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            best_hit <= 1'b0;
            best_t   <= T_MAX;
            best_idx <= '0;
            finish   <= 1'b0;
            err      <= 1'b0;
        end else if (bus.i_start) begin
            best_hit <= 1'b0;
            best_t   <= T_MAX;
            best_idx <= '0;
            finish   <= (bus.i_tri_cnt == '0);
            err      <= 1'b0;
        end else begin
            if (sv) begin
                best_hit <= 1'b1;
                if (!best_hit || better(st, sidx, best_t, best_idx)) begin
                    best_t   <= st;
                    best_idx <= sidx;
                end
            end
            if (finish_set) begin
                finish <= 1'b1;
            end
            if (err_set) begin
                err <= 1'b1;
            end
        end
    end

`ifdef HIT_REDUCE_COUNT_EN
    logic [IDX_W-1:0] hit_cnt;
    logic [IDX_W:0]   hit_sum;

    assign hit_sum = {1'b0, hit_cnt} + (IDX_W+1)'($countones(hit_lanes));

    // Saturating count of qualifying hits accepted during the batch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_cnt <= '0;
        end else if (bus.i_start) begin
            hit_cnt <= '0;
        end else if (accept) begin
            hit_cnt <= hit_sum[IDX_W] ? {IDX_W{1'b1}} : hit_sum[IDX_W-1:0];
        end
    end

    assign bus.o_hit_cnt = hit_cnt;
`endif

    assign bus.o_busy   = (state == S_RUN) || (state == S_DRAIN);
    assign bus.o_hit    = best_hit;
    assign bus.o_t      = best_t;
    assign bus.o_idx    = best_idx;
    assign bus.o_finish = finish;
    assign bus.o_err    = err;
endmodule

// File: tb/tb_closest_hit_reducer.sv
// Directed testbench for closest_hit_reducer (LANES=4, T_W=32, IDX_W=32, MIN_T=0).
// Hit-count checks are compiled in only when HIT_REDUCE_COUNT_EN is defined.
module tb_closest_hit_reducer;
    localparam logic [63:0] TMAX = 64'h7FFF_FFFF;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fails;

    closest_hit_reducer_if #(.LANES(4), .T_W(32), .IDX_W(32)) bus ();

    closest_hit_reducer #(.LANES(4), .T_W(32), .IDX_W(32), .MIN_T(0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        bus.i_start   = 1'b0;
        bus.i_tri_cnt = '0;
        bus.i_valid   = '0;
        bus.i_hit     = '0;
        bus.i_t       = '0;
        bus.i_idx     = '0;
    endtask

    task automatic startBatch(input logic [31:0] cnt);
        bus.i_start   = 1'b1;
        bus.i_tri_cnt = cnt;
        tick();
        idleInputs();
    endtask

    task automatic applyStimulus(input logic [3:0] valid, input logic [3:0] hit,
                                 input logic [127:0] t, input logic [127:0] idx);
        bus.i_valid = valid;
        bus.i_hit   = hit;
        bus.i_t     = t;
        bus.i_idx   = idx;
        tick();
        idleInputs();
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        idleInputs();
        reset = 1'b1;
        #12;
        checkOutput("rst_busy",   64'(bus.o_busy),   64'd0);
        checkOutput("rst_hit",    64'(bus.o_hit),    64'd0);
        checkOutput("rst_t",      64'(bus.o_t),      TMAX);
        checkOutput("rst_finish", 64'(bus.o_finish), 64'd0);
        reset = 1'b0;
        tick();

        // Reset mid-batch, then a normal one-result batch.
        startBatch(32'd5);
        applyStimulus(4'b0011, 4'b0011, {32'd0, 32'd0, 32'h200, 32'h100},
                      {32'd0, 32'd0, 32'd2, 32'd1});
        checkOutput("mid_busy_pre", 64'(bus.o_busy), 64'd1);
        #2 reset = 1'b1;
        #1;
        checkOutput("arst_busy",   64'(bus.o_busy),   64'd0);
        checkOutput("arst_hit",    64'(bus.o_hit),    64'd0);
        checkOutput("arst_t",      64'(bus.o_t),      TMAX);
        checkOutput("arst_idx",    64'(bus.o_idx),    64'd0);
        checkOutput("arst_finish", 64'(bus.o_finish), 64'd0);
        checkOutput("arst_err",    64'(bus.o_err),    64'd0);
        #2 reset = 1'b0;
        tick();
        startBatch(32'd1);
        applyStimulus(4'b0001, 4'b0001, {32'd0, 32'd0, 32'd0, 32'h40},
                      {32'd0, 32'd0, 32'd0, 32'd3});
        checkOutput("one_finish_early", 64'(bus.o_finish), 64'd0);
        tick();
        checkOutput("one_finish", 64'(bus.o_finish), 64'd1);
        checkOutput("one_t",      64'(bus.o_t),      64'h40);
        checkOutput("one_idx",    64'(bus.o_idx),    64'd3);
        checkOutput("one_busy",   64'(bus.o_busy),   64'd0);

        // Four lanes in one cycle with a t tie broken by the smaller index.
        startBatch(32'd4);
        applyStimulus(4'b1111, 4'b1111,
                      {32'h18000, 32'h20000, 32'h18000, 32'h30000},
                      {32'd4, 32'd2, 32'd9, 32'd7});
        checkOutput("tie_finish_early", 64'(bus.o_finish), 64'd0);
        checkOutput("tie_busy_drain",   64'(bus.o_busy),   64'd1);
        tick();
        checkOutput("tie_finish", 64'(bus.o_finish), 64'd1);
        checkOutput("tie_t",      64'(bus.o_t),      64'h18000);
        checkOutput("tie_idx",    64'(bus.o_idx),    64'd4);
        checkOutput("tie_hit",    64'(bus.o_hit),    64'd1);
        checkOutput("tie_err",    64'(bus.o_err),    64'd0);

        // Six results, no hits.
        startBatch(32'd6);
        for (int c = 0; c < 3; c++) begin
            applyStimulus(4'b0011, 4'b0000, {32'd0, 32'd0, 32'h10, 32'h20},
                          {32'd0, 32'd0, 32'd1, 32'd2});
        end
        tick();
        checkOutput("miss_hit",    64'(bus.o_hit),    64'd0);
        checkOutput("miss_t",      64'(bus.o_t),      TMAX);
        checkOutput("miss_finish", 64'(bus.o_finish), 64'd1);
        checkOutput("miss_err",    64'(bus.o_err),    64'd0);

        // Empty batch completes at once without ever going busy.
        startBatch(32'd0);
        checkOutput("zero_finish", 64'(bus.o_finish), 64'd1);
        checkOutput("zero_busy",   64'(bus.o_busy),   64'd0);
        tick();
        checkOutput("zero_busy2",  64'(bus.o_busy),   64'd0);

        // Overrun: four results for a batch of three.
        startBatch(32'd3);
        applyStimulus(4'b1111, 4'b1111, {32'd8, 32'd7, 32'd6, 32'd5},
                      {32'd3, 32'd2, 32'd1, 32'd0});
        checkOutput("over_err", 64'(bus.o_err), 64'd1);
        tick();
        checkOutput("over_finish", 64'(bus.o_finish), 64'd1);
        checkOutput("over_err2",   64'(bus.o_err),    64'd1);

        // Abort: the earlier partial batch must leave no trace.
        startBatch(32'd8);
        applyStimulus(4'b0011, 4'b0011, {32'd0, 32'd0, 32'h200, 32'h100},
                      {32'd0, 32'd0, 32'd2, 32'd1});
        startBatch(32'd1);
        applyStimulus(4'b0001, 4'b0001, {32'd0, 32'd0, 32'd0, 32'h500},
                      {32'd0, 32'd0, 32'd0, 32'd9});
        tick();
        checkOutput("abort_t",      64'(bus.o_t),      64'h500);
        checkOutput("abort_idx",    64'(bus.o_idx),    64'd9);
        checkOutput("abort_finish", 64'(bus.o_finish), 64'd1);
        checkOutput("abort_err",    64'(bus.o_err),    64'd0);

        // Negative t is below MIN_T and must be ignored.
        startBatch(32'd2);
        applyStimulus(4'b0011, 4'b0011, {32'd0, 32'd0, 32'h700, 32'hFFFF_FFFF},
                      {32'd0, 32'd0, 32'd2, 32'd1});
        tick();
        checkOutput("neg_t",   64'(bus.o_t),   64'h700);
        checkOutput("neg_idx", 64'(bus.o_idx), 64'd2);

        // Results arriving after completion are flagged and ignored.
        applyStimulus(4'b0001, 4'b0001, {32'd0, 32'd0, 32'd0, 32'h1},
                      {32'd0, 32'd0, 32'd0, 32'd5});
        tick();
        checkOutput("late_err", 64'(bus.o_err), 64'd1);
        checkOutput("late_t",   64'(bus.o_t),   64'h700);

`ifdef HIT_REDUCE_COUNT_EN
        // Five qualifying hits out of eight results.
        startBatch(32'd8);
        applyStimulus(4'b1111, 4'b1011, {32'h40, 32'h30, 32'h20, 32'h10},
                      {32'd4, 32'd3, 32'd2, 32'd1});
        applyStimulus(4'b1111, 4'b0101, {32'h80, 32'h70, 32'h60, 32'h50},
                      {32'd8, 32'd7, 32'd6, 32'd5});
        tick();
        checkOutput("cnt_hits",   64'(bus.o_hit_cnt), 64'd5);
        checkOutput("cnt_t",      64'(bus.o_t),       64'h10);
        checkOutput("cnt_finish", 64'(bus.o_finish),  64'd1);
        startBatch(32'd2);
        checkOutput("cnt_clear",  64'(bus.o_hit_cnt), 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
